autosa_csb_master: RTL and testbench
====================================

Name: autosa_csb_master

Overview:
- CSB initiator that drives the 63-bit csb2xx request bus and consumes the 34-bit xx2csb response bus.
- It is the requester-side counterpart of the per-unit CSB responders, such as the GLB register stubs.
- It accepts register read/write commands from a local command port, packs and issues them, and tracks the single outstanding transaction.
- Completions are returned with read data, error and timeout status.

Parameters:
- TIMEOUT_CYCLES, 1023: cycles to wait in WAIT_RESP before forcing a timeout completion. 0 disables the timeout.
- CNT_W, 16: width of the spurious-response counter (saturating).

Ports:
- autosa_core_clk  in  1  clock
- autosa_core_rstn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_addr  in  22  register word address
- cmd_wdat  in  32  write data
- cmd_write  in  1  1=write, 0=read
- cmd_nposted  in  1  write requires a response
- cmd_srcpriv  in  1  privileged source
- cmd_wrbe  in  4  write byte enables
- cmd_level  in  2  security level
- csb_req_pd  out  63  packed request
- csb_req_pvld  out  1  request valid
- csb_req_prdy  in  1  request ready
- csb_resp_pd  in  34  packed response
- csb_resp_valid  in  1  response valid (single-cycle, no backpressure)
- cpl_valid  out  1  completion pulse
- cpl_rdat  out  32  read data (0 for writes)
- cpl_error  out  1  responder error, kind mismatch, or timeout
- cpl_timeout  out  1  completion caused by timeout
- cpl_is_write  out  1  completion belongs to a write
- busy  out  1  state != IDLE
- spurious_cnt  out  CNT_W  responses received outside WAIT_RESP

Behaviour:
- **Request packing:** pd[21:0]=addr, [53:22]=wdat, [54]=write, [55]=nposted, [56]=srcpriv, [60:57]=wrbe, [62:61]=level. All fields are registered at command acceptance.
- **Response unpacking:** [31:0]=rdat, [32]=error, [33]=kind (0 read report, 1 write report).
- **Reset values:**
  - All outputs 0; state IDLE; timeout counter 0; spurious_cnt 0.
  - cmd_ready is 1 from the first cycle after reset deassertion (combinational from state).
- **State IDLE:**
  - cmd_ready=1.
  - On cmd_valid: capture the command, go to REQ. csb_req_pvld=1 from the next cycle.
- **State REQ:**
  - csb_req_pvld=1; pd held stable until csb_req_prdy=1.
  - On handshake with read or (write & nposted): go to WAIT_RESP and clear the timeout counter.
  - On handshake with a posted write: go to IDLE. No completion is generated.
- **State WAIT_RESP:**
  - The counter increments each cycle.
  - On csb_resp_valid: go to IDLE. Next cycle, pulse cpl_valid=1 for 1 cycle with:
    - cpl_rdat = rdat for reads, 0 for writes;
    - cpl_error = resp error | (kind != expected kind);
    - cpl_is_write = captured write; cpl_timeout=0.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with no response: go to IDLE and pulse cpl_valid with cpl_error=1, cpl_timeout=1, cpl_rdat=0.
  - A response in the same cycle the counter hits the limit wins: normal completion, no timeout.
- **Completion hold:** cpl_* data holds its last value between pulses.
- **Latency:**
  - Command accept to csb_req_pvld: 1 cycle.
  - Response to cpl_valid: 1 cycle.
  - A responder that answers 1 cycle after prdy gives 3 cycles from cmd accept (with prdy=1) to cpl_valid.
- **Spurious responses:** any csb_resp_valid while state != WAIT_RESP (including late responses after a timeout) is dropped, and spurious_cnt increments, saturating at all-ones.
- **Throughput:** at most one outstanding transaction. cmd_ready=0 in REQ and WAIT_RESP. A new command may be accepted in the same cycle cpl_valid pulses.
- **Reset mid-operation:** return to IDLE immediately and drop the outstanding transaction with no completion. csb_req_pvld drops asynchronously.

Test Plan:
1. **Read:** cmd read addr=0x00_1234, prdy=1, responder returns pd={1'b0,1'b0,32'hDEAD_BEEF} 1 cycle after handshake -> csb_req_pd[21:0]=0x1234, [54]=0; cpl_valid 3 cycles after accept, cpl_rdat=0xDEADBEEF, cpl_error=0, cpl_is_write=0.
2. **Posted write:** cmd write nposted=0, wdat=0xA5A5_5A5A, wrbe=0xF, level=2 -> pd[53:22]=0xA5A55A5A, [60:57]=0xF, [62:61]=2; no cpl_valid; busy=0 two cycles after accept.
3. **Backpressure:** prdy=0 for 5 cycles, then 1 -> pd stable and pvld=1 for 6 cycles, cmd_ready=0 throughout, exactly one handshake.
4. **Non-posted write with kind mismatch:** response pd[33]=0 -> cpl_valid with cpl_error=1, cpl_is_write=1, cpl_rdat=0.
5. **Timeout:** TIMEOUT_CYCLES=8, read with no response -> cpl_valid with cpl_timeout=1, cpl_error=1 after 8 WAIT cycles. A response arriving 2 cycles later gives no cpl_valid and spurious_cnt=1.
6. **Reset mid-operation:** assert rstn low during WAIT_RESP -> pvld=0, busy=0, no completion; the next command completes normally.

Source files
------------

// File: rtl/autosa_csb_master.sv
// CSB initiator: packs local register commands onto csb2xx, tracks one outstanding
// transaction and returns completions with read data, error and timeout status.
`timescale 1ns/1ps
module autosa_csb_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1023,
   parameter int unsigned CNT_W          = 16
) (
   input  logic              autosa_core_clk,
   input  logic              autosa_core_rstn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [21:0]       cmd_addr,
   input  logic [31:0]       cmd_wdat,
   input  logic              cmd_write,
   input  logic              cmd_nposted,
   input  logic              cmd_srcpriv,
   input  logic [3:0]        cmd_wrbe,
   input  logic [1:0]        cmd_level,
   output logic [62:0]       csb_req_pd,
   output logic              csb_req_pvld,
   input  logic              csb_req_prdy,
   input  logic [33:0]       csb_resp_pd,
   input  logic              csb_resp_valid,
   output logic              cpl_valid,
   output logic [31:0]       cpl_rdat,
   output logic              cpl_error,
   output logic              cpl_timeout,
   output logic              cpl_is_write,
   output logic              busy,
   output logic [CNT_W-1:0]  spurious_cnt
);

   localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   // Last wait-cycle index: the transition out of WAIT happens at the end of this cycle.
   localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   state_e           r_state;
   logic [62:0]      r_req_pd;
   logic [TW-1:0]    r_tcnt;
   logic [CNT_W-1:0] r_spur_cnt;
   logic             r_cpl_valid;
   logic [31:0]      r_cpl_rdat;
   logic             r_cpl_error;
   logic             r_cpl_timeout;
   logic             r_cpl_is_write;

   logic             w_req_write;
   logic             w_req_nposted;
   logic [31:0]      w_resp_rdat;
   logic             w_resp_err;
   logic             w_resp_kind;
   logic             w_timeout_hit;
   logic             w_spur_max;

   assign w_req_write   = r_req_pd[54];
   assign w_req_nposted = r_req_pd[55];
   assign w_resp_rdat   = csb_resp_pd[31:0];
   assign w_resp_err    = csb_resp_pd[32];
   assign w_resp_kind   = csb_resp_pd[33];
   assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_tcnt == TLIM);
   assign w_spur_max    = &r_spur_cnt;

   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         r_state        <= StIdle;
         r_req_pd       <= '0;
         r_tcnt         <= '0;
         r_spur_cnt     <= '0;
         r_cpl_valid    <= 1'b0;
         r_cpl_rdat     <= '0;
         r_cpl_error    <= 1'b0;
         r_cpl_timeout  <= 1'b0;
         r_cpl_is_write <= 1'b0;
      end else begin
         r_cpl_valid <= 1'b0;
         // Responses outside WAIT (including late ones after a timeout) are dropped.
         if (csb_resp_valid && (r_state != StWait) && !w_spur_max) begin
            r_spur_cnt <= r_spur_cnt + CNT_W'(1);
         end
         case (r_state)
            StIdle: begin
               if (cmd_valid) begin
                  r_req_pd <= {cmd_level, cmd_wrbe, cmd_srcpriv, cmd_nposted, cmd_write,
                               cmd_wdat, cmd_addr};
                  r_state  <= StReq;
               end
            end
            StReq: begin
               if (csb_req_prdy) begin
                  if (!w_req_write || w_req_nposted) begin
                     r_state <= StWait;
                     r_tcnt  <= '0;
                  end else begin
                     r_state <= StIdle;
                  end
               end
            end
            StWait: begin
               r_tcnt <= r_tcnt + TW'(1);
               if (csb_resp_valid) begin
                  r_state        <= StIdle;
                  r_cpl_valid    <= 1'b1;
                  r_cpl_rdat     <= w_req_write ? 32'h0 : w_resp_rdat;
                  r_cpl_error    <= w_resp_err | (w_resp_kind != w_req_write);
                  r_cpl_timeout  <= 1'b0;
                  r_cpl_is_write <= w_req_write;
               end else if (w_timeout_hit) begin
                  r_state        <= StIdle;
                  r_cpl_valid    <= 1'b1;
                  r_cpl_rdat     <= 32'h0;
                  r_cpl_error    <= 1'b1;
                  r_cpl_timeout  <= 1'b1;
                  r_cpl_is_write <= w_req_write;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Gating with reset keeps cmd_ready low while reset is held.
   assign cmd_ready    = autosa_core_rstn && (r_state == StIdle);
   assign csb_req_pvld = (r_state == StReq);
   assign busy         = (r_state != StIdle);
   assign csb_req_pd   = r_req_pd;
   assign cpl_valid    = r_cpl_valid;
   assign cpl_rdat     = r_cpl_rdat;
   assign cpl_error    = r_cpl_error;
   assign cpl_timeout  = r_cpl_timeout;
   assign cpl_is_write = r_cpl_is_write;
   assign spurious_cnt = r_spur_cnt;

endmodule

// File: tb/tb_autosa_csb_master.sv
// Self-checking bench for autosa_csb_master: randomized commands and responses checked
// against a field-level model of packing, completion and spurious counting.
`timescale 1ns/1ps
module tb_autosa_csb_master;

   localparam int unsigned TO = 8;
   localparam int unsigned CW = 3;
   localparam int unsigned SPUR_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rstn;
   logic          cmd_valid, cmd_ready, cmd_write, cmd_nposted, cmd_srcpriv;
   logic [21:0]   cmd_addr;
   logic [31:0]   cmd_wdat;
   logic [3:0]    cmd_wrbe;
   logic [1:0]    cmd_level;
   logic [62:0]   csb_req_pd;
   logic          csb_req_pvld, csb_req_prdy;
   logic [33:0]   csb_resp_pd;
   logic          csb_resp_valid;
   logic          cpl_valid, cpl_error, cpl_timeout, cpl_is_write, busy;
   logic [31:0]   cpl_rdat;
   logic [CW-1:0] spurious_cnt;

   int          checks = 0;
   int          errors = 0;
   int unsigned exp_spur = 0;
   logic [62:0] exp_pd;
   logic [34:0] last_cpl = '0;

   always #5 clk = ~clk;

   autosa_csb_master #(
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (CW)
   ) u_dut (
      .autosa_core_clk  (clk),
      .autosa_core_rstn (rstn),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_addr         (cmd_addr),
      .cmd_wdat         (cmd_wdat),
      .cmd_write        (cmd_write),
      .cmd_nposted      (cmd_nposted),
      .cmd_srcpriv      (cmd_srcpriv),
      .cmd_wrbe         (cmd_wrbe),
      .cmd_level        (cmd_level),
      .csb_req_pd       (csb_req_pd),
      .csb_req_pvld     (csb_req_pvld),
      .csb_req_prdy     (csb_req_prdy),
      .csb_resp_pd      (csb_resp_pd),
      .csb_resp_valid   (csb_resp_valid),
      .cpl_valid        (cpl_valid),
      .cpl_rdat         (cpl_rdat),
      .cpl_error        (cpl_error),
      .cpl_timeout      (cpl_timeout),
      .cpl_is_write     (cpl_is_write),
      .busy             (busy),
      .spurious_cnt     (spurious_cnt)
   );

   // Expected request word built field by field from the currently driven command.
   function automatic logic [62:0] cur_pd();
      logic [62:0] p;
      p = '0;
      p[21:0]  = cmd_addr;
      p[53:22] = cmd_wdat;
      p[54]    = cmd_write;
      p[55]    = cmd_nposted;
      p[56]    = cmd_srcpriv;
      p[60:57] = cmd_wrbe;
      p[62:61] = cmd_level;
      return p;
   endfunction

   // Expected {error, timeout, is_write, rdat} for a normal completion.
   function automatic logic [34:0] exp_cpl(input logic w, input logic [33:0] rsp);
      logic err;
      err = rsp[32] | (rsp[33] != w);
      return {err, 1'b0, w, (w ? 32'h0 : rsp[31:0])};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic w, input logic np);
      cmd_valid   = 1'b1;
      cmd_write   = w;
      cmd_nposted = np;
      cmd_addr    = 22'($urandom);
      cmd_wdat    = $urandom;
      cmd_srcpriv = 1'($urandom);
      cmd_wrbe    = 4'($urandom);
      cmd_level   = 2'($urandom);
      exp_pd      = cur_pd();
   endtask

   function automatic logic [33:0] rand_rsp();
      return {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 32'($urandom)};
   endfunction

   task automatic test_reset();
      checks++;
      if ({cmd_ready, csb_req_pvld, busy, cpl_valid, spurious_cnt, cpl_rdat, csb_req_pd} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%0b pvld=%0b busy=%0b cpl=%0b spur=%0d rdat=%h pd=%h exp all 0",
                  cmd_ready, csb_req_pvld, busy, cpl_valid, spurious_cnt, cpl_rdat, csb_req_pd);
      end
      @(negedge clk);
      rstn = 1'b1;
      tick();
      checks++;
      if ({cmd_ready, busy, csb_req_pvld} !== 3'b100) begin
         errors++;
         $display("FAIL reset_release got rdy/busy/pvld=%b exp 100", {cmd_ready, busy, csb_req_pvld});
      end
   endtask

   task automatic test_read();
      logic [33:0] rsp;
      logic [34:0] e;
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, 1'b0);
         csb_req_prdy = 1'b1;
         rsp = rand_rsp();
         if (i == 0) begin
            cmd_addr = 22'h001234;
            exp_pd   = cur_pd();
            rsp      = {1'b0, 1'b0, 32'hDEAD_BEEF};
         end
         tick();
         cmd_valid = 1'b0;
         checks++;
         if ({csb_req_pvld, cmd_ready, busy, csb_req_pd} !== {3'b101, exp_pd}) begin
            errors++;
            $display("FAIL read_req got %b %h exp 101 %h", {csb_req_pvld, cmd_ready, busy},
                     csb_req_pd, exp_pd);
         end
         tick();
         checks++;
         if ({csb_req_pvld, busy, cpl_valid} !== 3'b010) begin
            errors++;
            $display("FAIL read_wait got pvld/busy/cpl=%b exp 010", {csb_req_pvld, busy, cpl_valid});
         end
         csb_resp_valid = 1'b1;
         csb_resp_pd    = rsp;
         e = exp_cpl(1'b0, rsp);
         tick();
         csb_resp_valid = 1'b0;
         checks++;
         if ({cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat} !== {1'b1, e}) begin
            errors++;
            $display("FAIL read_cpl got %h exp %h",
                     {cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat}, {1'b1, e});
         end
         checks++;
         if ({cmd_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL read_idle got rdy/busy=%b exp 10", {cmd_ready, busy});
         end
         last_cpl = e;
         tick();
         checks++;
         if ({cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat} !== {1'b0, last_cpl}) begin
            errors++;
            $display("FAIL read_hold got %h exp %h",
                     {cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat}, {1'b0, last_cpl});
         end
      end
   endtask

   task automatic test_posted_write();
      for (int i = 0; i < 6; i++) begin
         issue(1'b1, 1'b0);
         csb_req_prdy = 1'b1;
         if (i == 0) begin
            cmd_wdat  = 32'hA5A5_5A5A;
            cmd_wrbe  = 4'hF;
            cmd_level = 2'd2;
            exp_pd    = cur_pd();
         end
         tick();
         cmd_valid = 1'b0;
         checks++;
         if ({csb_req_pvld, csb_req_pd} !== {1'b1, exp_pd}) begin
            errors++;
            $display("FAIL pw_req got pvld=%0b pd=%h exp 1 %h", csb_req_pvld, csb_req_pd, exp_pd);
         end
         tick();
         checks++;
         if ({busy, csb_req_pvld, cpl_valid, cmd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL pw_done got busy/pvld/cpl/rdy=%b exp 0001",
                     {busy, csb_req_pvld, cpl_valid, cmd_ready});
         end
         tick();
         checks++;
         if ({cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat} !== {1'b0, last_cpl}) begin
            errors++;
            $display("FAIL pw_nocpl got %h exp %h",
                     {cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat}, {1'b0, last_cpl});
         end
      end
   endtask

   task automatic test_backpressure();
      int          hs;
      logic [33:0] rsp;
      logic [34:0] e;
      hs = 0;
      issue(1'b0, 1'b0);
      csb_req_prdy = 1'b0;
      tick();
      // Keep offering different commands: none may be captured while busy.
      cmd_addr = ~cmd_addr;
      cmd_wdat = ~cmd_wdat;
      for (int c = 0; c < 6; c++) begin
         csb_req_prdy = (c == 5);
         checks++;
         if ({csb_req_pvld, cmd_ready, csb_req_pd} !== {2'b10, exp_pd}) begin
            errors++;
            $display("FAIL bp_hold cyc %0d got pvld/rdy=%b pd=%h exp 10 %h", c,
                     {csb_req_pvld, cmd_ready}, csb_req_pd, exp_pd);
         end
         if (csb_req_pvld && csb_req_prdy) hs++;
         tick();
      end
      cmd_valid    = 1'b0;
      csb_req_prdy = 1'b0;
      checks++;
      if ({hs, csb_req_pvld, busy} !== {32'd1, 2'b01}) begin
         errors++;
         $display("FAIL bp_handshake got hs=%0d pvld=%0b busy=%0b exp 1 0 1", hs, csb_req_pvld, busy);
      end
      rsp = rand_rsp();
      csb_resp_valid = 1'b1;
      csb_resp_pd    = rsp;
      e = exp_cpl(1'b0, rsp);
      tick();
      csb_resp_valid = 1'b0;
      checks++;
      if ({cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat} !== {1'b1, e}) begin
         errors++;
         $display("FAIL bp_cpl got %h exp %h",
                  {cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat}, {1'b1, e});
      end
      last_cpl = e;
      tick();
   endtask

   task automatic test_nposted_write();
      logic [33:0] rsp;
      logic [34:0] e;
      for (int i = 0; i < 6; i++) begin
         issue(1'b1, 1'b1);
         csb_req_prdy = 1'b1;
         rsp = rand_rsp();
         if (i == 0) rsp = {1'b0, 1'b0, 32'h1357_9BDF};
         tick();
         cmd_valid = 1'b0;
         checks++;
         if ({csb_req_pvld, csb_req_pd} !== {1'b1, exp_pd}) begin
            errors++;
            $display("FAIL npw_req got pvld=%0b pd=%h exp 1 %h", csb_req_pvld, csb_req_pd, exp_pd);
         end
         tick();
         csb_resp_valid = 1'b1;
         csb_resp_pd    = rsp;
         e = exp_cpl(1'b1, rsp);
         tick();
         csb_resp_valid = 1'b0;
         checks++;
         if ({cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat} !== {1'b1, e}) begin
            errors++;
            $display("FAIL npw_cpl it %0d got %h exp %h", i,
                     {cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat}, {1'b1, e});
         end
         last_cpl = e;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [33:0] rsp;
      logic [34:0] e;
      issue(1'b0, 1'b0);
      csb_req_prdy = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      rsp = rand_rsp();
      csb_resp_valid = 1'b1;
      csb_resp_pd    = rsp;
      e = exp_cpl(1'b0, rsp);
      tick();
      csb_resp_valid = 1'b0;
      last_cpl = e;
      // Offer the next command in the completion cycle.
      issue(1'b1, 1'b1);
      checks++;
      if ({cpl_valid, cmd_ready} !== 2'b11) begin
         errors++;
         $display("FAIL b2b_offer got cpl/rdy=%b exp 11", {cpl_valid, cmd_ready});
      end
      tick();
      cmd_valid = 1'b0;
      checks++;
      if ({csb_req_pvld, cpl_valid, csb_req_pd} !== {2'b10, exp_pd}) begin
         errors++;
         $display("FAIL b2b_accept got pvld/cpl=%b pd=%h exp 10 %h", {csb_req_pvld, cpl_valid},
                  csb_req_pd, exp_pd);
      end
      tick();
      rsp = rand_rsp();
      csb_resp_valid = 1'b1;
      csb_resp_pd    = rsp;
      e = exp_cpl(1'b1, rsp);
      tick();
      csb_resp_valid = 1'b0;
      checks++;
      if ({cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat} !== {1'b1, e}) begin
         errors++;
         $display("FAIL b2b_cpl got %h exp %h",
                  {cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat}, {1'b1, e});
      end
      last_cpl = e;
      tick();
   endtask

   task automatic test_timeout();
      logic [33:0] rsp;
      logic [34:0] e;
      issue(1'b0, 1'b0);
      csb_req_prdy = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int k = 0; k < int'(TO); k++) begin
         checks++;
         if ({busy, cpl_valid} !== 2'b10) begin
            errors++;
            $display("FAIL to_wait k %0d got busy/cpl=%b exp 10", k, {busy, cpl_valid});
         end
         tick();
      end
      e = {1'b1, 1'b1, 1'b0, 32'h0};
      checks++;
      if ({cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat, busy} !== {1'b1, e, 1'b0}) begin
         errors++;
         $display("FAIL to_cpl got %h busy=%0b exp %h busy=0",
                  {cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat}, busy, {1'b1, e});
      end
      last_cpl = e;
      tick();
      tick();
      csb_resp_valid = 1'b1;
      csb_resp_pd    = rand_rsp();
      tick();
      csb_resp_valid = 1'b0;
      if (exp_spur < SPUR_MAX) exp_spur++;
      checks++;
      if ({cpl_valid, busy, spurious_cnt} !== {2'b00, CW'(exp_spur)}) begin
         errors++;
         $display("FAIL to_late got cpl/busy=%b spur=%0d exp 00 %0d", {cpl_valid, busy},
                  spurious_cnt, exp_spur);
      end
      // Response in the last wait cycle beats the timeout.
      issue(1'b0, 1'b0);
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int k = 0; k < int'(TO) - 1; k++) tick();
      rsp = rand_rsp();
      csb_resp_valid = 1'b1;
      csb_resp_pd    = rsp;
      e = exp_cpl(1'b0, rsp);
      tick();
      csb_resp_valid = 1'b0;
      checks++;
      if ({cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat} !== {1'b1, e}) begin
         errors++;
         $display("FAIL to_race got %h exp %h",
                  {cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat}, {1'b1, e});
      end
      last_cpl = e;
      tick();
   endtask

   task automatic test_spurious();
      for (int i = 0; i < 9; i++) begin
         csb_resp_valid = 1'b1;
         csb_resp_pd    = rand_rsp();
         tick();
         csb_resp_valid = 1'b0;
         if (exp_spur < SPUR_MAX) exp_spur++;
         checks++;
         if ({cpl_valid, busy, spurious_cnt} !== {2'b00, CW'(exp_spur)}) begin
            errors++;
            $display("FAIL spur it %0d got cpl/busy=%b spur=%0d exp 00 %0d", i,
                     {cpl_valid, busy}, spurious_cnt, exp_spur);
         end
         if ($urandom_range(0, 1) == 1) tick();
      end
   endtask

   task automatic test_reset_mid();
      logic [33:0] rsp;
      logic [34:0] e;
      int          seen;
      seen = 0;
      // Reset while a request is pending on the bus.
      issue(1'b0, 1'b0);
      csb_req_prdy = 1'b0;
      tick();
      cmd_valid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({csb_req_pvld, busy, cmd_ready} !== 3'b000) begin
         errors++;
         $display("FAIL rst_req got pvld/busy/rdy=%b exp 000", {csb_req_pvld, busy, cmd_ready});
      end
      @(negedge clk);
      rstn = 1'b1;
      exp_spur = 0;
      last_cpl = '0;
      tick();
      // Reset while waiting for the response.
      issue(1'b0, 1'b0);
      csb_req_prdy = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({csb_req_pvld, busy, cmd_ready, cpl_valid, spurious_cnt} !== '0) begin
         errors++;
         $display("FAIL rst_wait got pvld/busy/rdy/cpl=%b spur=%0d exp 0000 0",
                  {csb_req_pvld, busy, cmd_ready, cpl_valid}, spurious_cnt);
      end
      @(negedge clk);
      rstn = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (cpl_valid) seen++;
      end
      checks++;
      if ({seen, busy} !== {32'd0, 1'b0}) begin
         errors++;
         $display("FAIL rst_nocpl got cpl_count=%0d busy=%0b exp 0 0", seen, busy);
      end
      issue(1'b0, 1'b0);
      tick();
      cmd_valid = 1'b0;
      tick();
      rsp = rand_rsp();
      csb_resp_valid = 1'b1;
      csb_resp_pd    = rsp;
      e = exp_cpl(1'b0, rsp);
      tick();
      csb_resp_valid = 1'b0;
      checks++;
      if ({cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat, spurious_cnt} !==
          {1'b1, e, CW'(exp_spur)}) begin
         errors++;
         $display("FAIL rst_after got %h spur=%0d exp %h spur=%0d",
                  {cpl_valid, cpl_error, cpl_timeout, cpl_is_write, cpl_rdat}, spurious_cnt,
                  {1'b1, e}, exp_spur);
      end
      tick();
   endtask

   initial begin
      rstn           = 1'b0;
      cmd_valid      = 1'b0;
      cmd_addr       = '0;
      cmd_wdat       = '0;
      cmd_write      = 1'b0;
      cmd_nposted    = 1'b0;
      cmd_srcpriv    = 1'b0;
      cmd_wrbe       = '0;
      cmd_level      = '0;
      csb_req_prdy   = 1'b0;
      csb_resp_pd    = '0;
      csb_resp_valid = 1'b0;
      repeat (2) tick();
      test_reset();
      test_read();
      test_posted_write();
      test_backpressure();
      test_nposted_write();
      test_back_to_back();
      test_timeout();
      test_spurious();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no end of run exp finish before 200us");
      $fatal(1, "watchdog");
   end

endmodule
